regfile_write_arbiter: RTL and testbench

Arbitrates the single write port of the 32x32 register file between the in-order pipeline writeback (port A) and the multi-cycle/long-latency unit (port B). A starvation guard bounds how long port B waits. A pending-write scoreboard lets issue logic detect RAW hazards on registers owed by port B. The block sits between the writeback stage and the register file, and drives `RDaddr`/`RDdata`/`RegWrite`/`is_pos` directly.

---
 rtl/regfile_pkg.sv | 16 +
 rtl/regfile_scoreboard.sv | 43 ++++
 rtl/regfile_write_arbiter.sv | 91 +++++++++
 tb/tb_regfile_write_arbiter.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared register file write types and widths.
// Used by writeback, the long-latency unit and the write arbiter.
package regfile_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int DATA_W     = 32;
    localparam int POS_W      = 4;
    localparam int NUM_REGS   = 32;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] addr;
        logic [DATA_W-1:0]     data;
        logic [POS_W-1:0]      pos;
    } wr_req_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard for registers owed by the long-latency port.
// Reservation wins over a same-cycle clear of the same register.
module regfile_scoreboard
    import regfile_pkg::*;
(
    input  logic                  clk_i,
    input  logic                  reset,
    input  logic                  rsv_valid_i,
    input  logic [REG_ADDR_W-1:0] rsv_addr_i,
    input  logic                  clr_valid_i,
    input  logic [REG_ADDR_W-1:0] clr_addr_i,
    input  logic [REG_ADDR_W-1:0] rs_addr_i,
    input  logic [REG_ADDR_W-1:0] rt_addr_i,
    output logic                  hazard_o,
    output logic [NUM_REGS-1:0]   busy_o
);

    logic [NUM_REGS-1:0] r_busy;
    logic [NUM_REGS-1:0] w_busy_nxt;

    always_comb begin
        w_busy_nxt = r_busy;
        if (clr_valid_i) begin
            w_busy_nxt[clr_addr_i] = 1'b0;
        end
        if (rsv_valid_i && (rsv_addr_i != '0)) begin
            w_busy_nxt[rsv_addr_i] = 1'b1;
        end
        w_busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk_i) begin
        if (reset) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_busy_nxt;
        end
    end

    assign hazard_o = r_busy[rs_addr_i] | r_busy[rt_addr_i];
    assign busy_o   = r_busy;

endmodule

// File: rtl/regfile_write_arbiter.sv
// Register file write-port arbiter: pipeline writeback (A) vs long-latency unit (B),
// with a starvation guard on B and a pending-write scoreboard for hazard detection.
module regfile_write_arbiter
    import regfile_pkg::*;
#(
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = 3
) (
    input  logic                  clk_i,
    input  logic                  reset,
    input  logic                  a_valid_i,
    input  logic [REG_ADDR_W-1:0] a_addr_i,
    input  logic [DATA_W-1:0]     a_data_i,
    input  logic [POS_W-1:0]      a_pos_i,
    output logic                  a_stall_o,
    input  logic                  b_valid_i,
    input  logic [REG_ADDR_W-1:0] b_addr_i,
    input  logic [DATA_W-1:0]     b_data_i,
    input  logic [POS_W-1:0]      b_pos_i,
    output logic                  b_ready_o,
    input  logic                  rsv_valid_i,
    input  logic [REG_ADDR_W-1:0] rsv_addr_i,
    input  logic [REG_ADDR_W-1:0] rs_addr_i,
    input  logic [REG_ADDR_W-1:0] rt_addr_i,
    output logic                  hazard_o,
    output logic [NUM_REGS-1:0]   busy_o,
    output logic [REG_ADDR_W-1:0] RDaddr_o,
    output logic [DATA_W-1:0]     RDdata_o,
    output logic [POS_W-1:0]      is_pos_o,
    output logic                  RegWrite_o
);

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    logic [CNT_W-1:0] r_starve_cnt;
    logic             w_starved;
    logic             w_grant_a;
    logic             w_grant_b;
    wr_req_t          w_req_a;
    wr_req_t          w_req_b;
    wr_req_t          w_wr;

    assign w_req_a   = '{addr: a_addr_i, data: a_data_i, pos: a_pos_i};
    assign w_req_b   = '{addr: b_addr_i, data: b_data_i, pos: b_pos_i};

    assign w_starved = (r_starve_cnt == LIMIT);
    assign w_grant_b = b_valid_i && (!a_valid_i || w_starved);
    assign w_grant_a = a_valid_i && !w_grant_b;

    assign b_ready_o = w_grant_b;
    assign a_stall_o = a_valid_i && w_grant_b;

    always_comb begin
        w_wr = '0;
        unique case (1'b1)
            w_grant_b: w_wr = w_req_b;
            w_grant_a: w_wr = w_req_a;
            default:   w_wr = '0;
        endcase
    end

    // x0 writes still complete the handshake but never reach the file
    assign RDaddr_o   = w_wr.addr;
    assign RDdata_o   = w_wr.data;
    assign is_pos_o   = w_wr.pos;
    assign RegWrite_o = (w_grant_a || w_grant_b) && (w_wr.addr != '0);

    always_ff @(posedge clk_i) begin
        if (reset) begin
            r_starve_cnt <= '0;
        end else if (!b_valid_i || w_grant_b) begin
            r_starve_cnt <= '0;
        end else if (w_grant_a && !w_starved) begin
            r_starve_cnt <= r_starve_cnt + 1'b1;
        end
    end

    regfile_scoreboard u_sb (
        .clk_i       (clk_i),
        .reset       (reset),
        .rsv_valid_i (rsv_valid_i),
        .rsv_addr_i  (rsv_addr_i),
        .clr_valid_i (w_grant_b),
        .clr_addr_i  (b_addr_i),
        .rs_addr_i   (rs_addr_i),
        .rt_addr_i   (rt_addr_i),
        .hazard_o    (hazard_o),
        .busy_o      (busy_o)
    );

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter: vector table plus
// starvation, scoreboard and reset sequences against a register file model.
module tb_regfile_write_arbiter;

    logic        clk_i = 1'b0;
    logic        reset;
    logic        a_valid_i;
    logic [4:0]  a_addr_i;
    logic [31:0] a_data_i;
    logic [3:0]  a_pos_i;
    logic        a_stall_o;
    logic        b_valid_i;
    logic [4:0]  b_addr_i;
    logic [31:0] b_data_i;
    logic [3:0]  b_pos_i;
    logic        b_ready_o;
    logic        rsv_valid_i;
    logic [4:0]  rsv_addr_i;
    logic [4:0]  rs_addr_i;
    logic [4:0]  rt_addr_i;
    logic        hazard_o;
    logic [31:0] busy_o;
    logic [4:0]  RDaddr_o;
    logic [31:0] RDdata_o;
    logic [3:0]  is_pos_o;
    logic        RegWrite_o;

    int total = 0;
    int bad   = 0;

    logic [31:0] rf [32];

    regfile_write_arbiter #(.STARVE_LIMIT(4), .CNT_W(3)) dut (
        .clk_i(clk_i), .reset(reset),
        .a_valid_i(a_valid_i), .a_addr_i(a_addr_i),
        .a_data_i(a_data_i), .a_pos_i(a_pos_i), .a_stall_o(a_stall_o),
        .b_valid_i(b_valid_i), .b_addr_i(b_addr_i),
        .b_data_i(b_data_i), .b_pos_i(b_pos_i), .b_ready_o(b_ready_o),
        .rsv_valid_i(rsv_valid_i), .rsv_addr_i(rsv_addr_i),
        .rs_addr_i(rs_addr_i), .rt_addr_i(rt_addr_i),
        .hazard_o(hazard_o), .busy_o(busy_o),
        .RDaddr_o(RDaddr_o), .RDdata_o(RDdata_o),
        .is_pos_o(is_pos_o), .RegWrite_o(RegWrite_o)
    );

    always #5 clk_i = ~clk_i;

    // register file model: captures on the falling edge, x0 hardwired
    always @(negedge clk_i) begin
        if (RegWrite_o) rf[RDaddr_o] = RDdata_o;
        rf[0] = 32'h0;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        string       name;
        logic        av;
        logic [4:0]  aa;
        logic [31:0] ad;
        logic [3:0]  ap;
        logic        bv;
        logic [4:0]  ba;
        logic [31:0] bd;
        logic [3:0]  bp;
        logic        e_stall;
        logic        e_ready;
        logic        e_we;
        logic [4:0]  e_addr;
        logic [31:0] e_data;
        logic [3:0]  e_pos;
    } vec_t;

    vec_t vecs [7];

    task automatic chk(input string n, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", n, act, exp);
        end
    endtask

    task automatic idle();
        a_valid_i   = 0; a_addr_i = 0; a_data_i = 0; a_pos_i = 0;
        b_valid_i   = 0; b_addr_i = 0; b_data_i = 0; b_pos_i = 0;
        rsv_valid_i = 0; rsv_addr_i = 0;
        rs_addr_i   = 0; rt_addr_i = 0;
    endtask

    task automatic next_cycle();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        vecs[0] = '{"idle", 0, 0, 0, 0, 0, 0, 0, 0,
                    0, 0, 0, 0, 0, 0};
        vecs[1] = '{"a_x5", 1, 5, 32'h1234_5678, 3, 0, 0, 0, 0,
                    0, 0, 1, 5, 32'h1234_5678, 3};
        vecs[2] = '{"b_x7", 0, 0, 0, 0, 1, 7, 32'hDEAD_BEEF, 2,
                    0, 1, 1, 7, 32'hDEAD_BEEF, 2};
        vecs[3] = '{"a_x0", 1, 0, 32'hFFFF_FFFF, 1, 0, 0, 0, 0,
                    0, 0, 0, 0, 32'hFFFF_FFFF, 1};
        vecs[4] = '{"both_a", 1, 10, 32'hA, 6, 1, 11, 32'hB, 9,
                    0, 0, 1, 10, 32'hA, 6};
        vecs[5] = '{"b_x0", 0, 0, 0, 0, 1, 0, 32'h55, 4,
                    0, 1, 0, 0, 32'h55, 4};
        vecs[6] = '{"a_x31", 1, 31, 32'h8000_0001, 15, 0, 0, 0, 0,
                    0, 0, 1, 31, 32'h8000_0001, 15};

        for (int i = 0; i < 32; i++) rf[i] = 32'h0;
        idle();
        reset = 1;
        next_cycle();
        next_cycle();
        reset = 0;
        @(negedge clk_i);
        chk("rst_stall", {31'b0, a_stall_o}, 0);
        chk("rst_ready", {31'b0, b_ready_o}, 0);
        chk("rst_we",    {31'b0, RegWrite_o}, 0);
        chk("rst_addr",  {27'b0, RDaddr_o}, 0);
        chk("rst_data",  RDdata_o, 0);
        chk("rst_pos",   {28'b0, is_pos_o}, 0);
        chk("rst_busy",  busy_o, 0);
        chk("rst_haz",   {31'b0, hazard_o}, 0);

        for (int i = 0; i < 7; i++) begin
            next_cycle();
            idle();
            a_valid_i = vecs[i].av; a_addr_i = vecs[i].aa;
            a_data_i  = vecs[i].ad; a_pos_i  = vecs[i].ap;
            b_valid_i = vecs[i].bv; b_addr_i = vecs[i].ba;
            b_data_i  = vecs[i].bd; b_pos_i  = vecs[i].bp;
            @(negedge clk_i);
            chk({vecs[i].name, "_stall"}, {31'b0, a_stall_o}, {31'b0, vecs[i].e_stall});
            chk({vecs[i].name, "_ready"}, {31'b0, b_ready_o}, {31'b0, vecs[i].e_ready});
            chk({vecs[i].name, "_we"},    {31'b0, RegWrite_o}, {31'b0, vecs[i].e_we});
            chk({vecs[i].name, "_addr"},  {27'b0, RDaddr_o}, {27'b0, vecs[i].e_addr});
            chk({vecs[i].name, "_data"},  RDdata_o, vecs[i].e_data);
            chk({vecs[i].name, "_pos"},   {28'b0, is_pos_o}, {28'b0, vecs[i].e_pos});
            next_cycle();
            idle();
        end
        @(negedge clk_i);
        chk("rf_x5", rf[5], 32'h1234_5678);
        chk("rf_x7", rf[7], 32'hDEAD_BEEF);
        chk("rf_x0", rf[0], 32'h0);
        chk("rf_x31", rf[31], 32'h8000_0001);

        // continuous A with B pending: B forced through every fifth cycle
        for (int c = 0; c < 10; c++) begin
            next_cycle();
            idle();
            a_valid_i = 1; a_addr_i = 5'(c + 1); a_data_i = 32'(c);
            b_valid_i = 1; b_addr_i = 12; b_data_i = 32'hB0B0;
            @(negedge clk_i);
            chk($sformatf("starve_ready_c%0d", c), {31'b0, b_ready_o},
                {31'b0, (c % 5) == 4});
            chk($sformatf("starve_stall_c%0d", c), {31'b0, a_stall_o},
                {31'b0, (c % 5) == 4});
            chk($sformatf("starve_addr_c%0d", c), {27'b0, RDaddr_o},
                ((c % 5) == 4) ? 32'd12 : 32'(c + 1));
        end
        next_cycle();
        idle();

        // scoreboard: reserve x9 in cycle 2, B writes x9 in cycle 6
        for (int c = 0; c < 9; c++) begin
            idle();
            rs_addr_i = 9;
            if (c == 2) begin rsv_valid_i = 1; rsv_addr_i = 9; end
            if (c == 6) begin b_valid_i = 1; b_addr_i = 9; b_data_i = 32'h99; end
            @(negedge clk_i);
            chk($sformatf("sb_haz_c%0d", c), {31'b0, hazard_o},
                {31'b0, (c >= 3) && (c <= 6)});
            next_cycle();
        end
        chk("rf_x9", rf[9], 32'h99);

        idle();
        rsv_valid_i = 1; rsv_addr_i = 9;
        next_cycle();
        idle();
        rsv_valid_i = 1; rsv_addr_i = 9;
        b_valid_i = 1; b_addr_i = 9; b_data_i = 32'h1;
        next_cycle();
        idle();
        rt_addr_i = 9;
        @(negedge clk_i);
        chk("sb_set_wins", {31'b0, busy_o[9]}, 1);
        chk("sb_rt_haz", {31'b0, hazard_o}, 1);
        next_cycle();
        b_valid_i = 1; b_addr_i = 9;
        next_cycle();
        idle();
        rsv_valid_i = 1; rsv_addr_i = 0;
        next_cycle();
        idle();
        @(negedge clk_i);
        chk("sb_cleared", busy_o, 0);

        // reservations dropped by reset
        rsv_valid_i = 1; rsv_addr_i = 3;
        next_cycle();
        rsv_addr_i = 4;
        next_cycle();
        idle();
        @(negedge clk_i);
        chk("sb_x3x4", busy_o, 32'h18);
        reset = 1;
        next_cycle();
        reset = 0;
        rs_addr_i = 3; rt_addr_i = 4;
        @(negedge clk_i);
        chk("rst2_busy", busy_o, 0);
        chk("rst2_haz", {31'b0, hazard_o}, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
